// File: rtl/mac_accum_pipe.sv
// Two-stage unsigned multiply-accumulate: stage 1 registers a*b, stage 2 folds
// it into a frame accumulator and presents the frame sum over valid/ready.

module mac_bk_adder #(
    parameter int W = 20
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int TOP = 1 << ($clog2(W) - 1);

    logic [W-1:0] g, p, gg, pp;

    // Brent-Kung prefix: up-sweep builds power-of-two spans, down-sweep fills the gaps.
    always_comb begin
        g  = x & y;
        p  = x ^ y;
        gg = g;
        pp = p;
        for (int d = 1; d < W; d = d * 2) begin
            for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = TOP; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        s  = p ^ {gg[W-2:0], 1'b0};
        co = gg[W-1];
    end
endmodule

module mac_accum_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20   // must be >= 2*DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);
    logic                en, accept;
    logic [2*DATA_W-1:0] mul;
    logic                s1_valid, s1_last;
    logic [ACC_W-1:0]    prod, acc, sum;
    logic                ovf_acc, carry;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en && !clear;
    assign accept   = in_valid && in_ready;
    assign mul      = a * b;

    mac_bk_adder #(.W(ACC_W)) u_add (
        .x  (acc),
        .y  (prod),
        .s  (sum),
        .co (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            // Abort drops the in-flight element too; a held result stays put.
            s1_valid <= 1'b0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            if (en) out_valid <= 1'b0;
        end else if (en) begin
            s1_valid  <= accept;
            out_valid <= s1_valid && s1_last;
            if (accept) begin
                prod    <= ACC_W'(mul);
                s1_last <= in_last;
            end
            if (s1_valid) begin
                if (s1_last) begin
                    acc_out  <= sum;
                    overflow <= ovf_acc | carry;
                    acc      <= '0;
                    ovf_acc  <= 1'b0;
                end else begin
                    acc     <= sum;
                    ovf_acc <= ovf_acc | carry;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_accum_pipe.sv
// Directed bench for mac_accum_pipe with a frame-level sum model and per-cycle compare.

module tb_mac_accum_pipe;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam longint MODV = 64'd1 << ACC_W;

    logic              clk = 0;
    logic              rst_n, clear, in_valid, in_ready, in_last;
    logic [DATA_W-1:0] a, b;
    logic              out_valid, out_ready, overflow;
    logic [ACC_W-1:0]  acc_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        longint sum;
        bit     ovf;
        int     due;
    } exp_t;

    exp_t   q[$];
    longint run = 0;
    bit     run_ovf = 0;
    longint log_sum[$];
    bit     log_ovf[$];

    mac_accum_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: frame sums in plain integer arithmetic; each finished frame is due two cycles on.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            run = 0;
            run_ovf = 0;
        end else begin
            check("in_ready", in_ready, !clear && !(out_valid && !out_ready));
            if (q.size() > 0 && q[0].due <= cyc) check("out_valid_due", out_valid, 1);
            if (out_valid) begin
                if (q.size() == 0 || q[0].due > cyc) begin
                    check("out_valid_early", out_valid, 0);
                end else begin
                    check("acc_out", acc_out, q[0].sum);
                    check("overflow", overflow, q[0].ovf);
                    if (out_ready) begin
                        log_sum.push_back(q[0].sum);
                        log_ovf.push_back(q[0].ovf);
                        void'(q.pop_front());
                    end
                end
            end
            if (clear) begin
                run = 0;
                run_ovf = 0;
            end else if (in_valid && in_ready) begin
                run = run + longint'(a) * longint'(b);
                if (run >= MODV) begin
                    run = run % MODV;
                    run_ovf = 1;
                end
                if (in_last) begin
                    q.push_back('{sum: run, ovf: run_ovf, due: cyc + 2});
                    run = 0;
                    run_ovf = 0;
                end
            end
        end
    end

    task automatic send(input int av, input int bv, input bit last);
        int n = 0;
        in_valid = 1;
        a = DATA_W'(av);
        b = DATA_W'(bv);
        in_last = last;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        in_last = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint exp_s[9] = '{98, 56849, 1, 10, 6, 255, 4, 4, 9};
        bit     exp_o[9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        rst_n = 0; clear = 0; in_valid = 0; in_last = 0; a = 0; b = 0; out_ready = 1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        idle(2);

        // 1: basic frame
        send(3, 4, 0); send(5, 6, 0); send(7, 8, 1);
        idle(4);

        // 2: overflow frame then clean frame
        for (int i = 0; i < 17; i++) send(255, 255, i == 16);
        send(1, 1, 1);
        idle(4);

        // 3: backpressure
        send(1, 1, 0); send(3, 3, 1);
        out_ready = 0;
        idle(3);
        check("bp_in_ready", in_ready, 0);
        check("bp_acc_out", acc_out, 10);
        fork
            send(2, 3, 1);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        idle(4);

        // 4: single-element frames back to back
        send(255, 1, 1); send(2, 2, 1);
        idle(4);

        // 5: clear mid-frame
        send(9, 9, 0); send(9, 9, 0);
        in_valid = 0; clear = 1;
        @(negedge clk);
        check("clear_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clear = 0;
        send(2, 2, 1);
        idle(4);

        // 6: reset mid-frame
        send(5, 5, 0); send(4, 4, 0);
        idle(1);
        #1 rst_n = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_acc_out", acc_out, 0);
        idle(2);
        rst_n = 1;
        send(3, 3, 1);
        idle(4);

        check("log_count", log_sum.size(), 9);
        for (int i = 0; i < 9 && i < log_sum.size(); i++) begin
            check($sformatf("log_sum[%0d]", i), log_sum[i], exp_s[i]);
            check($sformatf("log_ovf[%0d]", i), log_ovf[i], exp_o[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
